timestamp_snap_master: RTL and testbench

TIMESTAMP_SNAP_MASTER -- requirements
Module: timestamp_snap_master

---
 rtl/tsm_pkg.sv | 33 +++
 rtl/tsm_snap_assembler.sv | 42 ++++
 rtl/timestamp_snap_master.sv | 179 +++++++++++++++++
 tb/tb_timestamp_snap_master.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsm_pkg.sv
// Shared constants and types for the timestamp snapshot master: timer register map,
// control bit positions and the master FSM state encoding.
package tsm_pkg;

  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
  localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
  localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
  localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
  localparam logic [3:0] ADDR_SNAP0   = 4'd6;
  localparam logic [3:0] ADDR_SNAP1   = 4'd7;
  localparam logic [3:0] ADDR_SNAP2   = 4'd8;
  localparam logic [3:0] ADDR_SNAP3   = 4'd9;

  localparam int unsigned STOP  = 3;
  localparam int unsigned START = 2;
  localparam int unsigned CONT  = 1;
  localparam int unsigned ITO   = 0;

  // Control bits the timer implements; anything outside this set is written as zero.
  localparam logic [3:0] CTRL_MASK = 4'((1 << STOP) | (1 << START) | (1 << CONT) | (1 << ITO));

  typedef enum logic [2:0] {
    StIdle,
    StCfgWr,
    StSnapWr,
    StSnapRd,
    StAckWr,
    StAckWait
  } tsm_state_e;

endpackage

// File: rtl/tsm_snap_assembler.sv
// Collects four timer snapshot halfwords (low first) into a 64-bit value and pulses done
// when the fourth halfword lands. rd_i marks the address phase; data arrives one cycle later.
module tsm_snap_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_i,
  input  logic [15:0] readdata_i,
  output logic [63:0] value_o,
  output logic        done_o
);

  logic        rd_q;
  logic [1:0]  cnt_q;
  logic [47:0] shift_q;
  logic [63:0] value_q;
  logic        done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= 1'b0;
      cnt_q   <= 2'd0;
      shift_q <= 48'h0;
      value_q <= 64'h0;
      done_q  <= 1'b0;
    end else begin
      rd_q   <= rd_i;
      done_q <= 1'b0;
      if (rd_q) begin
        shift_q <= {readdata_i, shift_q[47:16]};
        cnt_q   <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          value_q <= {readdata_i, shift_q};
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign value_o = value_q;
  assign done_o  = done_q;

endmodule

// File: rtl/timestamp_snap_master.sv
// Avalon-MM master that programs a halfword-mapped timer, snapshots its 64-bit counter and
// acknowledges its timeout interrupt. IRQ handling exists only when TSM_IRQ_ACK_EN is defined.
module timestamp_snap_master
  import tsm_pkg::*;
#(
  parameter logic [3:0] CFG_CONTROL = 4'b0110
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_valid,
  input  logic [63:0] cfg_period,
  output logic        cfg_ready,
  output logic        cfg_done,
  input  logic        snap_req,
  output logic        snap_ready,
  output logic [63:0] ts_value,
  output logic        ts_valid,
  input  logic        tmr_irq,
  output logic [15:0] event_count,
  output logic [3:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata
);

  tsm_state_e  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] period_q, period_d;
  logic        cfg_done_q, cfg_done_d;
  logic        rd_active;
  logic        irq_take;

`ifdef TSM_IRQ_ACK_EN
  logic [15:0] event_count_q, event_count_d;
  assign irq_take    = tmr_irq;
  assign event_count = event_count_q;
`else
  logic unused_irq;
  assign unused_irq  = tmr_irq;
  assign irq_take    = 1'b0;
  assign event_count = 16'h0;
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    period_d       = period_q;
    cfg_done_d     = 1'b0;
    rd_active      = 1'b0;
    avm_address    = ADDR_STATUS;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = 16'h0;
`ifdef TSM_IRQ_ACK_EN
    event_count_d  = event_count_q;
`endif
    unique case (state_q)
      StIdle: begin
        idx_d = 3'd0;
        if (cfg_valid) begin
          state_d  = StCfgWr;
          period_d = cfg_period;
        end else if (irq_take) begin
          state_d = StAckWr;
        end else if (snap_req) begin
          state_d = StSnapWr;
        end
      end
      StCfgWr: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        case (idx_q)
          3'd0: begin
            avm_address   = ADDR_PERIOD0;
            avm_writedata = period_q[15:0];
          end
          3'd1: begin
            avm_address   = ADDR_PERIOD1;
            avm_writedata = period_q[31:16];
          end
          3'd2: begin
            avm_address   = ADDR_PERIOD2;
            avm_writedata = period_q[47:32];
          end
          3'd3: begin
            avm_address   = ADDR_PERIOD3;
            avm_writedata = period_q[63:48];
          end
          default: begin
            avm_address   = ADDR_CONTROL;
            avm_writedata = {12'h0, CFG_CONTROL & CTRL_MASK};
          end
        endcase
        if (idx_q == 3'd4) begin
          state_d    = StIdle;
          cfg_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StSnapWr: begin
        // Any write to the first snapshot register freezes the counter into all four.
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_SNAP0;
        state_d        = StSnapRd;
        idx_d          = 3'd0;
      end
      StSnapRd: begin
        rd_active = 1'b1;
        case (idx_q[1:0])
          2'd0:    avm_address = ADDR_SNAP0;
          2'd1:    avm_address = ADDR_SNAP1;
          2'd2:    avm_address = ADDR_SNAP2;
          default: avm_address = ADDR_SNAP3;
        endcase
        if (idx_q[1:0] == 2'd3) begin
          state_d = StIdle;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
`ifdef TSM_IRQ_ACK_EN
      StAckWr: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_STATUS;
        event_count_d  = event_count_q + 16'd1;
        state_d        = StAckWait;
      end
      StAckWait: begin
        // Gives the timer a cycle to drop its irq before it is sampled again.
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      period_q   <= 64'h0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      period_q   <= period_d;
      cfg_done_q <= cfg_done_d;
    end
  end

`ifdef TSM_IRQ_ACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_count_q <= 16'h0;
    end else begin
      event_count_q <= event_count_d;
    end
  end
`endif

  assign cfg_ready  = (state_q == StIdle);
  assign snap_ready = (state_q == StIdle);
  assign cfg_done   = cfg_done_q;

  tsm_snap_assembler u_assembler (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_i       (rd_active),
    .readdata_i (avm_readdata),
    .value_o    (ts_value),
    .done_o     (ts_valid)
  );

endmodule

// File: tb/tb_timestamp_snap_master.sv
// Directed bench for timestamp_snap_master with a registered-readdata timer model.
`timescale 1ns/1ps
module tb_timestamp_snap_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [63:0] cfg_period = 64'h0;
  logic        snap_req = 1'b0;
  logic        tmr_irq = 1'b0;
  logic [15:0] avm_readdata = 16'h0;
  logic        cfg_ready, cfg_done, snap_ready, ts_valid;
  logic [63:0] ts_value;
  logic [15:0] event_count, avm_writedata;
  logic [3:0]  avm_address;
  logic        avm_chipselect, avm_write_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;
  int wr0_total = 0;
  int exp_ev = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [15:0] data;
  } bus_t;

  bus_t        wr_log[$];
  bus_t        rd_log[$];
  int          tsv_log[$];
  int          done_log[$];
  logic [15:0] snap_mem [4];

  timestamp_snap_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_valid      (cfg_valid),
    .cfg_period     (cfg_period),
    .cfg_ready      (cfg_ready),
    .cfg_done       (cfg_done),
    .snap_req       (snap_req),
    .snap_ready     (snap_ready),
    .ts_value       (ts_value),
    .ts_valid       (ts_valid),
    .tmr_irq        (tmr_irq),
    .event_count    (event_count),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata)
  );

  always #5 clk = ~clk;

  // Timer model: readdata is registered from the address of the previous cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    case (avm_address)
      4'd6:    avm_readdata <= snap_mem[0];
      4'd7:    avm_readdata <= snap_mem[1];
      4'd8:    avm_readdata <= snap_mem[2];
      4'd9:    avm_readdata <= snap_mem[3];
      default: avm_readdata <= 16'h0;
    endcase
  end

  always @(negedge clk) begin
    if (avm_chipselect && !avm_write_n) begin
      wr_log.push_back('{cyc, avm_address, avm_writedata});
      if (avm_address == 4'd0) wr0_total++;
    end else if (!avm_chipselect && avm_address != 4'd0) begin
      rd_log.push_back('{cyc, avm_address, 16'h0});
    end
    if (avm_chipselect == avm_write_n) viol++;
    if (!avm_chipselect && avm_writedata != 16'h0) viol++;
    if (cfg_ready != snap_ready) viol++;
    if (ts_valid) tsv_log.push_back(cyc);
    if (cfg_done) done_log.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    tsv_log.delete();
    done_log.delete();
  endtask

  task automatic do_cfg(input logic [63:0] p, output int acc);
    int n = 0;
    cfg_period = p;
    cfg_valid  = 1'b1;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
    end
    chk("cfg_accept", cfg_ready, 1);
    acc = cyc + 1;
    step();
    cfg_valid  = 1'b0;
    cfg_period = ~p;
  endtask

  task automatic do_snap(output int acc);
    int n = 0;
    snap_req = 1'b1;
    while (!snap_ready && n < 50) begin
      step();
      n++;
    end
    chk("snap_accept", snap_ready, 1);
    acc = cyc + 1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic run_snap(input string tag, input logic [63:0] old_v, input logic [63:0] new_v);
    int a;
    clear_logs();
    do_snap(a);
    repeat (5) step();
    chk({tag, "_hold"}, ts_value, old_v);
    chk({tag, "_early"}, ts_valid, 0);
    step();
    chk({tag, "_valid"}, ts_valid, 1);
    chk({tag, "_value"}, ts_value, new_v);
    repeat (3) step();
    chk({tag, "_nvalid"}, tsv_log.size(), 1);
    chk({tag, "_stable"}, ts_value, new_v);
    chk({tag, "_nwr"}, wr_log.size(), 1);
    if (wr_log.size() >= 1) begin
      chk({tag, "_wr_addr"}, wr_log[0].addr, 6);
      chk({tag, "_wr_data"}, wr_log[0].data, 0);
      chk({tag, "_wr_cyc"}, wr_log[0].cyc, a);
    end
    chk({tag, "_nrd"}, rd_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_log.size()) begin
        chk({tag, "_rd_addr"}, rd_log[i].addr, 6 + i);
        chk({tag, "_rd_cyc"}, rd_log[i].cyc, a + 1 + i);
      end
    end
  endtask

  task automatic test_cfg();
    logic [3:0]  ea [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    logic [15:0] ed [5] = '{16'h03E8, 16'h0000, 16'h0001, 16'h0000, 16'h0006};
    int a;
    clear_logs();
    do_cfg(64'h0000_0001_0000_03E8, a);
    chk("cfg_ready_busy", cfg_ready, 0);
    chk("snap_ready_busy", snap_ready, 0);
    repeat (8) step();
    chk("cfg_nwr", wr_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_log.size()) begin
        chk("cfg_wr_addr", wr_log[i].addr, ea[i]);
        chk("cfg_wr_data", wr_log[i].data, ed[i]);
        chk("cfg_wr_cyc", wr_log[i].cyc, a + i);
      end
    end
    chk("cfg_done_cnt", done_log.size(), 1);
    if (done_log.size() >= 1) chk("cfg_done_cyc", done_log[0], a + 5);
  endtask

  task automatic test_simul();
`ifdef TSM_IRQ_ACK_EN
    logic [3:0] ea [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd0, 4'd6};
`else
    logic [3:0] ea [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd6};
`endif
    logic [15:0] ed [5] = '{16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h0006};
    clear_logs();
    snap_mem[0] = 16'h0001;
    snap_mem[1] = 16'h0002;
    snap_mem[2] = 16'h0003;
    snap_mem[3] = 16'h0004;
    cfg_period = 64'hAAAA_BBBB_CCCC_DDDD;
    cfg_valid  = 1'b1;
    snap_req   = 1'b1;
`ifdef TSM_IRQ_ACK_EN
    tmr_irq = 1'b1;
    exp_ev++;
`endif
    for (int n = 0; n < 60; n++) begin
      step();
      for (int k = 0; k < wr_log.size(); k++) begin
        if (wr_log[k].addr == 4'd2) cfg_valid = 1'b0;
        if (wr_log[k].addr == 4'd6) snap_req = 1'b0;
`ifdef TSM_IRQ_ACK_EN
        if (wr_log[k].addr == 4'd0) tmr_irq = 1'b0;
`endif
      end
    end
    chk("sim_nwr", wr_log.size(), $size(ea));
    for (int i = 0; i < $size(ea); i++) begin
      if (i < wr_log.size()) chk("sim_wr_addr", wr_log[i].addr, ea[i]);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < wr_log.size()) chk("sim_wr_data", wr_log[i].data, ed[i]);
    end
    chk("sim_done_cnt", done_log.size(), 1);
    chk("sim_tsv_cnt", tsv_log.size(), 1);
    chk("sim_ts_value", ts_value, 64'h0004_0003_0002_0001);
    chk("sim_event_count", event_count, exp_ev);
  endtask

`ifdef TSM_IRQ_ACK_EN
  task automatic irq_once();
    int base = wr0_total;
    int n = 0;
    tmr_irq = 1'b1;
    while (wr0_total == base && n < 20) begin
      step();
      n++;
    end
    tmr_irq = 1'b0;
    exp_ev = (exp_ev + 1) % 65536;
    repeat (3) step();
  endtask

  task automatic test_irq();
    int base = wr0_total;
    repeat (5) irq_once();
    chk("irq_wr0_cnt", wr0_total - base, 5);
    chk("irq_event_count", event_count, exp_ev);
    // Jump the counter to the wrap point instead of spending 65535 acknowledge sequences.
    force dut.event_count_q = 16'hFFFF;
    #1;
    release dut.event_count_q;
    exp_ev = 16'hFFFF;
    step();
    chk("wrap_preload", event_count, 16'hFFFF);
    base = wr0_total;
    repeat (2) irq_once();
    chk("wrap_event_count", event_count, 16'h0001);
    chk("wrap_wr0_cnt", wr0_total - base, 2);
  endtask
`endif

  task automatic test_reset_mid();
    int a;
    clear_logs();
    snap_mem[0] = 16'hAAAA;
    snap_mem[1] = 16'hBBBB;
    snap_mem[2] = 16'hCCCC;
    snap_mem[3] = 16'hDDDD;
    do_snap(a);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_addr", avm_address, 0);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_wn", avm_write_n, 1);
    chk("rst_wd", avm_writedata, 0);
    chk("rst_ts_value", ts_value, 0);
    chk("rst_ts_valid", ts_valid, 0);
    chk("rst_snap_ready", snap_ready, 1);
    chk("rst_event_count", event_count, 0);
    exp_ev = 0;
    step();
    step();
    reset_n = 1'b1;
    repeat (8) step();
    chk("rst_no_tsv", tsv_log.size(), 0);
    chk("rst_nrd", rd_log.size(), 2);
    chk("rst_bus_idle", {avm_chipselect, avm_write_n, avm_address}, 6'b010000);
    snap_mem[0] = 16'h0F0F;
    snap_mem[1] = 16'h1E1E;
    snap_mem[2] = 16'h2D2D;
    snap_mem[3] = 16'h3C3C;
    run_snap("rec", 64'h0, 64'h3C3C_2D2D_1E1E_0F0F);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifndef TSM_IRQ_ACK_EN
    tmr_irq = 1'b1;
`endif
    reset_n = 1'b0;
    repeat (2) step();
    chk("reset_addr", avm_address, 0);
    chk("reset_cs", avm_chipselect, 0);
    chk("reset_wn", avm_write_n, 1);
    chk("reset_wd", avm_writedata, 0);
    chk("reset_ts_value", ts_value, 0);
    chk("reset_ts_valid", ts_valid, 0);
    chk("reset_cfg_done", cfg_done, 0);
    chk("reset_event_count", event_count, 0);
    chk("reset_cfg_ready", cfg_ready, 1);
    reset_n = 1'b1;
    step();

    test_cfg();

    snap_mem[0] = 16'h1234;
    snap_mem[1] = 16'h5678;
    snap_mem[2] = 16'h9ABC;
    snap_mem[3] = 16'hDEF0;
    run_snap("snap1", 64'h0, 64'hDEF0_9ABC_5678_1234);
    snap_mem[0] = 16'h1111;
    snap_mem[1] = 16'h2222;
    snap_mem[2] = 16'h3333;
    snap_mem[3] = 16'h4444;
    run_snap("snap2", 64'hDEF0_9ABC_5678_1234, 64'h4444_3333_2222_1111);

    test_simul();
`ifdef TSM_IRQ_ACK_EN
    test_irq();
`endif
    test_reset_mid();

`ifndef TSM_IRQ_ACK_EN
    chk("noack_wr0_total", wr0_total, 0);
    chk("noack_event_count", event_count, 0);
`endif
    chk("bus_protocol_viol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
